shared_port_arbiter: RTL

- Round-robin arbiter and sequencer for one shared WIDTH-bit memory/register port used by up to NUM_REQ requesters.
- Owns the select line of the port's input mux. Each grant is held until the requester releases it.
- A fixed one-cycle turnaround follows every grant so the mux output settles.
- Sits between the requesting pipeline units (load/store, lookup table walker, etc.) and the single data-memory port.

---
 rtl/shared_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared WIDTH-bit port; grants are held until released.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module shared_port_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [SEL_W-1:0]           select,
  output logic [WIDTH-1:0]           port_addr,
  output logic [WIDTH-1:0]           port_wdata,
  output logic                       port_we,
  output logic                       timeout_pulse
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_param
    $error("shared_port_arbiter: illegal NUM_REQ or MAX_HOLD");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                        state;
  logic [SEL_W-1:0]              rr_ptr;
  logic [SEL_W-1:0]              pick;
  logic                          pick_vld;
  logic [SEL_W-1:0]              next_ptr;
  logic                          revoke;
  logic                          in_grant;
  logic [NUM_REQ-1:0][WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][WIDTH-1:0] wdata_arr;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  // Two passes: lowest requester overall (the wrap case), then overridden by the
  // lowest requester at or above rr_ptr if one exists.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick     = SEL_W'(i);
        pick_vld = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) >= rr_ptr)) pick = SEL_W'(i);
    end
  end

  assign next_ptr = (select == SEL_W'(NUM_REQ - 1)) ? '0 : select + SEL_W'(1);

  assign in_grant   = (state == GRANT);
  assign port_addr  = in_grant ? addr_arr[select]  : '0;
  assign port_wdata = in_grant ? wdata_arr[select] : '0;
  assign port_we    = in_grant & req_we[select] & req[select] & grant_valid;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign revoke = in_grant && req[select] && (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= revoke;
      if (state == IDLE)  hold_cnt <= '0;
      else if (in_grant)  hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign revoke        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      select      <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= GRANT;
            grant       <= NUM_REQ'(1) << pick;
            grant_valid <= 1'b1;
            select      <= pick;
          end
        end
        GRANT: begin
          if (!req[select] || revoke) begin
            state       <= RELEASE;
            grant       <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
